lke_cam_match: RTL
==================

# lke_cam_match

Exact/ternary match front end of a lookup engine stage. Latches one PHV plus its extracted key from the key extractor and compares the key in parallel against a register-based table of NUM_ENTRIES ternary entries. It then priority-encodes the hits and presents the PHV, the matching index and a hit flag to the downstream action-RAM lookup part as a single-cycle valid pulse. The table is written through a simple synchronous config port driven by the stage's control-path decoder.

## Interface
- PHV_LEN, 4*8*64+256: PHV width in bits.
- KEY_LEN, 197: extracted key width.
- NUM_ENTRIES, 16: table depth; power of 2, 2..256.
- IDX_W, $clog2(NUM_ENTRIES): config address width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- phv_in  in  PHV_LEN  PHV from the key extractor.
- key_in  in  KEY_LEN  extracted key, aligned with phv_in.
- key_valid  in  1  phv_in/key_in valid; consumed only when ready_out=1.
- ready_out  out  1  block can accept a key this cycle.
- phv_out  out  PHV_LEN  latched PHV to the RAM part.
- phv_valid  out  1  one-cycle pulse qualifying phv_out/match_addr/if_match.
- match_addr  out  8  winning entry index, zero-extended.
- if_match  out  1  1 = some entry hit.
- ready_in  in  1  downstream RAM part ready.
- cfg_wr_en  in  1  write entry cfg_addr this edge.
- cfg_addr  in  IDX_W  entry index.
- cfg_key  in  KEY_LEN  entry key.
- cfg_mask  in  KEY_LEN  per-bit care mask; 1 = compare bit.
- cfg_entry_valid  in  1  entry valid bit to store.
- cfg_clr  in  1  invalidate all entries this edge.

## Operation
- Table per entry: key, mask, valid. Reset clears all fields to 0.
- Hit(i) = valid(i) && (((key_r ^ key(i)) & mask(i)) == 0). An all-zero mask is a wildcard.
- Winner is the lowest-index hit. With no hit: if_match=0, match_addr=0.
- FSM states IDLE, CMP, ENC, EMIT, GAP:
  - IDLE: ready_out=1. On key_valid, latch phv_in and key_in, go to CMP.
  - CMP: register the NUM_ENTRIES-bit hit vector against the current table contents, go to ENC.
  - ENC: priority-encode into match_addr/if_match and load phv_out, go to EMIT.
  - EMIT: hold all outputs. When ready_in=1, set phv_valid<=1 and go to GAP. Otherwise stay.
  - GAP: phv_valid<=0, go to IDLE. GAP guarantees at least one idle cycle between pulses, which the RAM part requires.
- ready_out = (state==IDLE), combinational from state only.
- Config:
  - Writes are legal in any state.
  - cfg_clr and cfg_wr_en on the same edge: clear wins, and the written entry ends up invalid.
  - A write takes effect at its edge. The CMP edge samples pre-edge contents, so a write on that same edge is not seen by that lookup.
- phv_out, match_addr and if_match hold their values until the next ENC. They are stable while phv_valid=1.

## Timing
- Reset values: ready_out=1 (IDLE), phv_valid=0, phv_out=0, match_addr=0, if_match=0. Reset also clears every table entry. Reset takes effect asynchronously, including mid-EMIT; the pending result is dropped.
- Key accepted at edge E0 → hit vector at E0+1 → outputs loaded at E0+2 → phv_valid high in the cycle after E0+3 if ready_in=1 at E0+3.
- Backpressure: each cycle ready_in=0 in EMIT adds one cycle. Outputs stay frozen and ready_out stays 0.
- Maximum throughput: one key per 5 cycles. key_valid while ready_out=0 is ignored; the upstream block holds it.
- Compare path is one cycle of NUM_ENTRIES×KEY_LEN XOR/AND reduction. Encode is one cycle.

## Test plan
- Reset, then write entry 3 with key=0xAB, mask=all-ones, valid=1. Send key 0xAB with phv_in=0x1234 → phv_valid pulses exactly 1 cycle after E0+3, match_addr=3, if_match=1, phv_out=0x1234.
- Entry 2: mask=0, valid=1 (wildcard). Entry 5: exact 0x55. Send key 0x55 → match_addr=2. Invalidate entry 2 and resend → match_addr=5.
- Send key 0x77 with no matching entry → if_match=0, match_addr=0, phv_valid still pulses once.
- Hold ready_in=0 for 6 cycles when EMIT is reached → phv_valid=0 and ready_out=0 throughout, outputs unchanged. ready_in=1 → one pulse, then GAP, then ready_out=1.
- Write entry 7 with key 0x99 on the CMP edge of a 0x99 lookup → if_match=0; the next 0x99 lookup → match_addr=7. Assert cfg_clr and cfg_wr_en together → the lookup misses.
- Assert rst in EMIT with ready_in=0 → all outputs return to reset values immediately, no phv_valid afterwards, and the table is empty.

Source files
------------

// File: rtl/lke_cam_match.sv
// Ternary CAM match front end: latches a PHV/key, compares it against a register table,
// priority-encodes the hits and emits one valid pulse per lookup with a guaranteed idle gap.
module lke_cam_match #(
  parameter int PHV_LEN     = 4*8*64+256,
  parameter int KEY_LEN     = 197,
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic [KEY_LEN-1:0] key_in,
  input  logic               key_valid,
  output logic               ready_out,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_valid,
  output logic [7:0]         match_addr,
  output logic               if_match,
  input  logic               ready_in,
  input  logic               cfg_wr_en,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [KEY_LEN-1:0] cfg_key,
  input  logic [KEY_LEN-1:0] cfg_mask,
  input  logic               cfg_entry_valid,
  input  logic               cfg_clr
);

  typedef enum logic [2:0] {S_IDLE, S_CMP, S_ENC, S_EMIT, S_GAP} state_t;

  state_t                 state_q;
  logic [KEY_LEN-1:0]     tkey_q  [NUM_ENTRIES];
  logic [KEY_LEN-1:0]     tmask_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tvalid_q;

  logic [PHV_LEN-1:0]     phv_q;
  logic [KEY_LEN-1:0]     key_q;
  logic [NUM_ENTRIES-1:0] hit_d, hit_q;
  logic [7:0]             enc_idx;
  logic                   enc_hit;
  logic [PHV_LEN-1:0]     phv_out_q;
  logic [7:0]             match_addr_q;
  logic                   if_match_q;
  logic                   phv_valid_q;

  // Clear is applied after the write so a same-edge write ends up invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        tkey_q[i]  <= '0;
        tmask_q[i] <= '0;
      end
      tvalid_q <= '0;
    end else begin
      if (cfg_wr_en) begin
        tkey_q[cfg_addr]   <= cfg_key;
        tmask_q[cfg_addr]  <= cfg_mask;
        tvalid_q[cfg_addr] <= cfg_entry_valid;
      end
      if (cfg_clr) tvalid_q <= '0;
    end
  end

  always_comb begin
    hit_d = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++)
      hit_d[i] = tvalid_q[i] && (((key_q ^ tkey_q[i]) & tmask_q[i]) == '0);
  end

  always_comb begin
    enc_idx = '0;
    enc_hit = |hit_q;
    for (int unsigned i = NUM_ENTRIES; i > 0; i--)
      if (hit_q[i-1]) enc_idx = 8'(i - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phv_q        <= '0;
      key_q        <= '0;
      hit_q        <= '0;
      phv_out_q    <= '0;
      match_addr_q <= '0;
      if_match_q   <= 1'b0;
      phv_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (key_valid) begin
          phv_q   <= phv_in;
          key_q   <= key_in;
          state_q <= S_CMP;
        end
        S_CMP: begin
          hit_q   <= hit_d;
          state_q <= S_ENC;
        end
        S_ENC: begin
          match_addr_q <= enc_idx;
          if_match_q   <= enc_hit;
          phv_out_q    <= phv_q;
          state_q      <= S_EMIT;
        end
        S_EMIT: if (ready_in) begin
          phv_valid_q <= 1'b1;
          state_q     <= S_GAP;
        end
        S_GAP: begin
          phv_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_out  = (state_q == S_IDLE);
  assign phv_out    = phv_out_q;
  assign match_addr = match_addr_q;
  assign if_match   = if_match_q;
  assign phv_valid  = phv_valid_q;

endmodule
